// File: rtl/matrix_mac_pkg.sv
// Shared helpers for the matrix MAC datapath: result conversion and counter sizing.
// Accumulators up to MAX_W bits are supported by sat_conv.
package matrix_mac_pkg;

  localparam int MAX_W = 64;

  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

  // acc arrives already sign- or zero-extended to MAX_W; caller keeps the low out_w bits.
  function automatic logic [MAX_W-1:0] sat_conv(input logic [MAX_W-1:0] acc,
                                                input int out_w,
                                                input logic is_signed,
                                                input logic sat);
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    sat_conv = acc;
    if (sat) begin
      if (is_signed) begin
        hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
        lo = ~hi;
        if ($signed(acc) > $signed(hi)) sat_conv = hi;
        else if ($signed(acc) < $signed(lo)) sat_conv = lo;
      end else begin
        hi = (MAX_W'(1) << out_w) - MAX_W'(1);
        if (acc > hi) sat_conv = hi;
      end
    end
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Stages S1+S2 of the MAC: per-lane products, then their sum extended to ACC_W.
// A sideband bus rides along so the accumulator sees beat flags aligned with the sum.
module mac_lane_sum
  import matrix_mac_pkg::*;
#(
  parameter int LANES  = 28,
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 0,
  parameter int SB_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  input  logic [SB_W-1:0]       in_sb,
  output logic                  out_valid,
  output logic [ACC_W-1:0]      out_sum,
  output logic [SB_W-1:0]       out_sb
);

  localparam int PW = 2 * DW;
  localparam logic [PW-1:0] OP_HI = {{DW{1'b1}}, {DW{1'b0}}};
  localparam logic [ACC_W-1:0] PROD_HI = ~((ACC_W'(1) << PW) - ACC_W'(1));

  logic                v1_q, v1_d, v2_q, v2_d;
  logic [LANES*PW-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [SB_W-1:0]     sb1_q, sb1_d, sb2_q, sb2_d;

  // Operands are widened to PW first so a PW-bit multiply yields the exact product either way.
  always_comb begin
    logic [PW-1:0]    opa;
    logic [PW-1:0]    opb;
    logic [ACC_W-1:0] lane;
    v1_d   = v1_q;
    v2_d   = v2_q;
    sb1_d  = sb1_q;
    sb2_d  = sb2_q;
    prod_d = prod_q;
    sum_d  = sum_q;
    opa    = '0;
    opb    = '0;
    lane   = '0;
    if (en) begin
      v1_d  = in_valid;
      sb1_d = in_sb;
      v2_d  = v1_q;
      sb2_d = sb1_q;
      for (int i = 0; i < LANES; i++) begin
        opa = PW'(in_a[i*DW +: DW]);
        opb = PW'(in_b[i*DW +: DW]);
        if (SIGNED != 0 && in_a[i*DW+DW-1]) opa = opa | OP_HI;
        if (SIGNED != 0 && in_b[i*DW+DW-1]) opb = opb | OP_HI;
        prod_d[i*PW +: PW] = opa * opb;
      end
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
        lane = ACC_W'(prod_q[i*PW +: PW]);
        if (SIGNED != 0 && prod_q[i*PW+PW-1]) lane = lane | PROD_HI;
        sum_d = sum_d + lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      sum_q  <= '0;
      sb1_q  <= '0;
      sb2_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      sb1_q  <= sb1_d;
      sb2_q  <= sb2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_sum   = sum_q;
  assign out_sb    = sb2_q;

endmodule

// File: rtl/matrix_mac_array.sv
// Pipelined multi-beat dot-product engine: lane sums accumulate per result, finished
// results are converted to OUT_W and packed PACK-per-word under valid/ready flow control.
module matrix_mac_array
  import matrix_mac_pkg::*;
#(
  parameter int LANES  = 28,
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int PACK   = 4,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*DW-1:0]      in_a,
  input  logic [LANES*DW-1:0]      in_b,
  input  logic [ACC_W-1:0]         in_bias,
  input  logic                     in_last,
  input  logic                     in_flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PACK*OUT_W-1:0]    out_data,
  output logic [cnt_w(PACK)-1:0]   out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CNT_W = cnt_w(PACK);
  localparam int SB_W  = ACC_W + 3;
  localparam logic [MAX_W-1:0] ACC_HI = ~((MAX_W'(1) << ACC_W) - MAX_W'(1));

  logic                  en;
  logic                  first_q, first_d;
  logic [SB_W-1:0]       sb_in, sb2;
  logic                  v2, flush2, last2, first2;
  logic [ACC_W-1:0]      sum2, bias2;
  logic                  v3_q, v3_d, last3_q, last3_d, flush3_q, flush3_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      pcnt_q, pcnt_d, out_cnt_q, out_cnt_d;
  logic [PACK*OUT_W-1:0] pack_q, pack_d, out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  // A held word freezes the whole pipeline, so a new word can never overwrite it.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign sb_in    = {in_flush & in_last, in_last, first_q, in_bias};
  assign {flush2, last2, first2, bias2} = sb2;

  mac_lane_sum #(
    .LANES (LANES),
    .DW    (DW),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED),
    .SB_W  (SB_W)
  ) u_lane_sum (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sb    (sb_in),
    .out_valid(v2),
    .out_sum  (sum2),
    .out_sb   (sb2)
  );

  // S3 accumulates; the result closed in S3 is converted and packed one stage later.
  always_comb begin
    logic [PACK*OUT_W-1:0] pack_n;
    logic [CNT_W-1:0]      cnt_n;
    logic [MAX_W-1:0]      acc_ext;
    first_d     = first_q;
    v3_d        = v3_q;
    last3_d     = last3_q;
    flush3_d    = flush3_q;
    acc_d       = acc_q;
    pcnt_d      = pcnt_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    pack_n      = pack_q;
    cnt_n       = pcnt_q;
    acc_ext     = MAX_W'(acc_q);
    if (SIGNED != 0 && acc_q[ACC_W-1]) acc_ext = acc_ext | ACC_HI;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (en) begin
      if (in_valid) first_d = in_last;
      v3_d     = v2;
      last3_d  = v2 && last2;
      flush3_d = v2 && flush2;
      if (v2) acc_d = (first2 ? bias2 : acc_q) + sum2;
      if (v3_q && last3_q) begin
        for (int k = 0; k < PACK; k++) begin
          if (pcnt_q == CNT_W'(k))
            pack_n[k*OUT_W +: OUT_W] = OUT_W'(sat_conv(acc_ext, OUT_W, SIGNED != 0, SAT != 0));
        end
        cnt_n = pcnt_q + CNT_W'(1);
        if (cnt_n == CNT_W'(PACK) || flush3_q) begin
          out_data_d  = pack_n;
          out_cnt_d   = cnt_n;
          out_valid_d = 1'b1;
          pcnt_d      = '0;
          pack_d      = '0;
        end else begin
          pack_d = pack_n;
          pcnt_d = cnt_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q     <= 1'b1;
      v3_q        <= 1'b0;
      last3_q     <= 1'b0;
      flush3_q    <= 1'b0;
      acc_q       <= '0;
      pcnt_q      <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      first_q     <= first_d;
      v3_q        <= v3_d;
      last3_q     <= last3_d;
      flush3_q    <= flush3_d;
      acc_q       <= acc_d;
      pcnt_q      <= pcnt_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_mac_array.sv
// Drives an unsigned/wrapping and a signed/saturating instance with identical beats and
// compares every emitted word against a transaction-level model of the dot-product rules.
module tb_matrix_mac_array;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int ACC_W = 40;
  localparam int OUT_W = 16;
  localparam int PACK  = 4;
  localparam longint M40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint HALF40 = 64'h0000_0080_0000_0000;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  cnt;
  } word_t;

  logic        clk, rst;
  logic [63:0] in_a, in_b;
  logic [39:0] in_bias;
  logic        in_last, in_flush, in_valid, out_ready;
  logic        in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [63:0] out_data_u, out_data_s;
  logic [2:0]  out_cnt_u, out_cnt_s;

  int n_checks = 0;
  int n_fail = 0;

  bit     m_first;
  longint acc_u, acc_s;
  longint slot_u[4];
  longint slot_s[4];
  int     pcnt;
  word_t  qu[$];
  word_t  qs[$];
  logic   accepted;

  matrix_mac_array #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W), .PACK(PACK),
                     .SIGNED(0), .SAT(0)) dut_u (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
    .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready_u), .out_data(out_data_u),
    .out_cnt(out_cnt_u), .out_valid(out_valid_u), .out_ready(out_ready)
  );

  matrix_mac_array #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W), .PACK(PACK),
                     .SIGNED(1), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
    .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
    .out_cnt(out_cnt_s), .out_valid(out_valid_s), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    acc_u = 0;
    acc_s = 0;
    pcnt = 0;
    for (int k = 0; k < 4; k++) begin
      slot_u[k] = 0;
      slot_s[k] = 0;
    end
    qu.delete();
    qs.delete();
  endtask

  // One accepted beat: plain integer dot product, accumulate mod 2^40, convert, pack.
  task automatic model_beat();
    longint su, ss, sv;
    word_t wu, ws;
    su = 0;
    ss = 0;
    for (int i = 0; i < LANES; i++) begin
      su += longint'(in_a[16*i +: 16]) * longint'(in_b[16*i +: 16]);
      ss += longint'($signed(in_a[16*i +: 16])) * longint'($signed(in_b[16*i +: 16]));
    end
    if (m_first) begin
      acc_u = longint'(in_bias);
      acc_s = longint'(in_bias);
    end
    acc_u = (acc_u + su) & M40;
    acc_s = (acc_s + ss) & M40;
    if (in_last) begin
      sv = (acc_s >= HALF40) ? acc_s - 2 * HALF40 : acc_s;
      if (sv > 32767) sv = 32767;
      if (sv < -32768) sv = -32768;
      slot_u[pcnt] = acc_u & 64'hFFFF;
      slot_s[pcnt] = sv & 64'hFFFF;
      pcnt++;
      if (pcnt == PACK || in_flush) begin
        wu.data = 0;
        ws.data = 0;
        for (int k = 0; k < 4; k++) begin
          wu.data |= 64'(slot_u[k]) << (16 * k);
          ws.data |= 64'(slot_s[k]) << (16 * k);
          slot_u[k] = 0;
          slot_s[k] = 0;
        end
        wu.cnt = 3'(pcnt);
        ws.cnt = 3'(pcnt);
        qu.push_back(wu);
        qs.push_back(ws);
        pcnt = 0;
      end
    end
    m_first = in_last;
  endtask

  task automatic tick();
    word_t w;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst) begin
      checkOutput("in_ready_match", 64'(in_ready_s), 64'(in_ready_u));
      if (out_valid_u && out_ready) begin
        if (qu.size() == 0) checkOutput("word_u_expected", 64'(qu.size()), 64'd1);
        else begin
          w = qu.pop_front();
          checkOutput("word_u_data", out_data_u, w.data);
          checkOutput("word_u_cnt", 64'(out_cnt_u), 64'(w.cnt));
        end
      end
      if (out_valid_s && out_ready) begin
        if (qs.size() == 0) checkOutput("word_s_expected", 64'(qs.size()), 64'd1);
        else begin
          w = qs.pop_front();
          checkOutput("word_s_data", out_data_s, w.data);
          checkOutput("word_s_cnt", 64'(out_cnt_s), 64'(w.cnt));
        end
      end
      if (in_valid && in_ready_u) begin
        model_beat();
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [39:0] bias,
                               input logic last, input logic flush);
    in_a = a;
    in_b = b;
    in_bias = bias;
    in_last = last;
    in_flush = flush;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    in_a = '0;
    in_b = '0;
    in_bias = '0;
    in_last = 1'b0;
    in_flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;

    checkOutput("rst_valid_u", 64'(out_valid_u), 64'd0);
    checkOutput("rst_data_u", out_data_u, 64'd0);
    checkOutput("rst_cnt_u", 64'(out_cnt_u), 64'd0);
    checkOutput("rst_ready_u", 64'(in_ready_u), 64'd1);
    checkOutput("rst_valid_s", 64'(out_valid_s), 64'd0);

    // Two-beat result with bias, flushed out alone: 5 + 8 + 8 = 21, visible after edge N+3.
    applyStimulus({4{16'd1}}, {4{16'd2}}, 40'd5, 1'b0, 1'b0);
    applyStimulus({4{16'd1}}, {4{16'd2}}, 40'd999, 1'b1, 1'b1);
    idle(1);
    checkOutput("lat_n1", 64'(out_valid_u), 64'd0);
    idle(1);
    checkOutput("lat_n2", 64'(out_valid_u), 64'd0);
    idle(1);
    checkOutput("lat_n3_valid", 64'(out_valid_u), 64'd1);
    checkOutput("lat_n3_data_u", out_data_u, 64'd21);
    checkOutput("lat_n3_data_s", out_data_s, 64'd21);
    checkOutput("lat_n3_cnt", 64'(out_cnt_u), 64'd1);
    idle(2);

    // Four single-beat results fill one word.
    for (int k = 1; k <= 4; k++) applyStimulus(64'(k), 64'd1, 40'd0, 1'b1, 1'b0);
    idle(2);
    checkOutput("pack_early", 64'(out_valid_u), 64'd0);
    idle(1);
    checkOutput("pack_valid", 64'(out_valid_u), 64'd1);
    checkOutput("pack_data", out_data_u, 64'h0004_0003_0002_0001);
    checkOutput("pack_cnt", 64'(out_cnt_u), 64'd4);
    idle(2);

    // Flush emits a partial word; the next result starts again at slot 0.
    applyStimulus(64'd7, 64'd1, 40'd0, 1'b1, 1'b0);
    applyStimulus(64'd9, 64'd1, 40'd0, 1'b1, 1'b1);
    idle(3);
    checkOutput("flush_data", out_data_u, 64'h0000_0000_0009_0007);
    checkOutput("flush_cnt", 64'(out_cnt_u), 64'd2);
    applyStimulus(64'd5, 64'd1, 40'd0, 1'b1, 1'b1);
    idle(3);
    checkOutput("after_flush_data", out_data_u, 64'd5);
    checkOutput("after_flush_cnt", 64'(out_cnt_u), 64'd1);
    idle(2);

    // Saturation on the signed instance, plain truncation on the unsigned one.
    applyStimulus(64'd0, 64'd0, 40'd40000, 1'b1, 1'b1);
    idle(3);
    checkOutput("sat_pos_s", out_data_s, 64'h7FFF);
    checkOutput("trunc_pos_u", out_data_u, 64'h9C40);
    applyStimulus(64'd0, 64'd0, 40'hFF_FFFF_63C0, 1'b1, 1'b1);
    idle(3);
    checkOutput("sat_neg_s", out_data_s, 64'h8000);
    checkOutput("trunc_neg_u", out_data_u, 64'h63C0);
    idle(2);

    // Backpressure: a held word stalls intake and stays stable.
    out_ready = 1'b0;
    applyStimulus(64'd11, 64'd1, 40'd0, 1'b1, 1'b1);
    idle(3);
    checkOutput("bp_valid", 64'(out_valid_u), 64'd1);
    in_a = 64'd6;
    in_b = 64'd1;
    in_bias = 40'd0;
    in_last = 1'b1;
    in_flush = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_in_ready", 64'(in_ready_u), 64'd0);
      checkOutput("bp_data_stable", out_data_u, 64'd11);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_resume_accept", 64'(accepted), 64'd1);
    idle(3);
    checkOutput("bp_next_data", out_data_u, 64'd6);
    idle(2);

    // Reset in the middle of a four-beat result discards the partial accumulation.
    applyStimulus(64'd1, 64'd1, 40'd100, 1'b0, 1'b0);
    applyStimulus(64'd1, 64'd1, 40'd100, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    checkOutput("mid_rst_valid", 64'(out_valid_u), 64'd0);
    checkOutput("mid_rst_data", out_data_u, 64'd0);
    checkOutput("mid_rst_cnt", 64'(out_cnt_u), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready_u), 64'd1);
    applyStimulus(64'd0, 64'd0, 40'd3, 1'b1, 1'b1);
    idle(3);
    checkOutput("post_rst_data", out_data_u, 64'd3);
    checkOutput("post_rst_cnt", 64'(out_cnt_u), 64'd1);
    idle(2);

    // Random beats, bubbles, flush with and without last, and random backpressure.
    for (int it = 0; it < 400; it++) begin
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_bias = {8'($urandom), $urandom};
      in_last = ($urandom % 3) == 0;
      in_flush = ($urandom % 4) == 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    out_ready = 1'b1;
    idle(8);
    checkOutput("drain_u", 64'(qu.size()), 64'd0);
    checkOutput("drain_s", 64'(qs.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mac_array.md
# matrix_mac_array

Parametrised, pipelined dot-product engine for the matrix datapath. Each accepted beat carries LANES operand pairs; their products are summed and accumulated over a variable number of beats, closed by `in_last`, with an optional per-result bias. Finished results are saturated or truncated to OUT_W and packed PACK-per-word into the output, under valid/ready backpressure on both sides. It generalises the fixed 28×16-bit, 4-result MAC set in width, lane count, packing depth and signedness, and adds multi-beat accumulation, bias, flush and backpressure.

## Interface
- LANES, 28, operand pairs per beat (≥1)
- DW, 16, operand width
- ACC_W, 40, accumulator width (≥2·DW)
- OUT_W, 16, packed result slot width (≤ACC_W)
- PACK, 4, results per output word (≥1)
- SIGNED, 0, 1 = two's-complement operands, bias and results
- SAT, 0, 1 = saturate to OUT_W range; 0 = keep low OUT_W bits
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_a  in  LANES·DW  operand A, lane i at [i·DW +: DW]
- in_b  in  LANES·DW  operand B, same layout
- in_bias  in  ACC_W  bias; sampled on the first beat of a result only
- in_last  in  1  beat closes the current result
- in_flush  in  1  valid only with in_last; emit the packed word even if partial
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready
- out_data  out  PACK·OUT_W  slot k at [k·OUT_W +: OUT_W]; slot 0 = oldest result
- out_cnt  out  $clog2(PACK+1)  filled slots, 1..PACK
- out_valid  out  1  word valid; held stable until taken
- out_ready  in  1  consumer accepts on out_valid && out_ready

## Operation
- Global advance `en = !out_valid || out_ready`; `in_ready = en`. When `en` = 0, every stage holds.
- S1 (register): LANES products, each 2·DW, sign- or zero-extended per SIGNED; in_last, in_flush, first flag and bias travel alongside.
- S2 (register): lane sum extended to ACC_W; wraps modulo 2^ACC_W.
- S3 (accumulate): first beat → `acc = bias + sum`; otherwise `acc = acc + sum`; wraps modulo 2^ACC_W. The first flag is 1 after reset and on the beat following any in_last beat; a single beat with in_last = 1 is a complete result.
- On an S3 beat with last: convert acc → OUT_W. With SAT = 1, clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1] when signed, or [0, 2^OUT_W−1] when unsigned. With SAT = 0, take acc[OUT_W−1:0]. Write the value to slot `pcnt`, then `pcnt++`.
- If `pcnt` reaches PACK, or the beat has flush: load out_data, out_cnt ← pcnt, out_valid ← 1, pcnt ← 0, and clear the pack register. Unfilled slots read 0.
- Flush with pcnt = 0 is impossible, because flush always accompanies a result.
- Because the whole pipeline stalls while out_valid && !out_ready, there is never a collision between a new word and a held word.

## Timing
- Reset values: out_valid 0, out_data 0, out_cnt 0, in_ready 1; internal state: pcnt 0, acc 0, first 1, all pipeline valids 0.
- Latency: a completing beat accepted at edge N drives out_valid high after edge N+3, provided no stall intervened. Each stall cycle adds one.
- Throughput: one beat per cycle while out_ready = 1.
- out_valid && out_ready at edge E with a new word completing at E: out_valid stays high with the new data, so there is no bubble.
- in_valid = 0 inserts a bubble. Bubbles neither accumulate nor change `first`.
- rst mid-result or mid-pack discards the partial acc, the packed slots and any pending word.
- in_flush without in_last is ignored.

## Structure
- Package `matrix_mac_pkg`:
  - function sat_conv(acc, SIGNED, SAT)
  - localparam CNT_W = $clog2(PACK+1)
- Sub-module `mac_lane_sum` (S1+S2: products, extension, adder tree, stage registers with enable). The top level holds the accumulator, packer and handshake.

## Test plan
- LANES=4, DW=16, unsigned; all a=1, b=2; bias=5; two beats, second with last; PACK=1 → out_data=21, out_cnt=1, out_valid after edge N+3.
- PACK=4; four single-beat results 1,2,3,4 (bias 0) → one word, slots 0..3 = 1,2,3,4, out_cnt=4; no out_valid before the fourth.
- Flush: two results 7, 9 with flush on the second → slots 7,9,0,0, out_cnt=2. A following result lands in slot 0.
- SIGNED=1, SAT=1, OUT_W=16: result 40000 → 0x7FFF; result −40000 → 0x8000. SAT=0: 40000 → 0x9C40.
- Backpressure: out_ready=0 for 5 cycles with a word pending → in_ready=0, out_data stable, no beats lost; out_ready=1 → stream continues with correct sums.
- Reset asserted after two beats of a four-beat result → outputs at reset values. The next result uses its own bias, with no residue from before reset.
